// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Purpose  : Multi-cycle sequencer that runs 32-bit word operations on a
//            shared 16-bit combinational ALU as two passes (low half, then
//            high half). Owns the architectural carry flag and chains the
//            low-half carry into the high-half pass. Flag ops (CLC/SEC) take
//            a single ALU pass and only touch the carry flag.
// Ports    : clk, rst            - clock (rising edge), async active-high reset
//            start, op, opa, opb - request; op/operands captured in IDLE
//            busy, done          - operation in progress / one-cycle finish
//            result, cy_flag     - registered 32-bit result and carry flag
//            alu_a, alu_b, alu_aluc, alu_cy_in - registered drive to the ALU
//            alu_z, alu_cy       - combinational ALU response
//            zero_flag           - only with ALU_SEQ_ZFLAG_EN defined
// Options  : ALU_SEQ_ZFLAG_EN - adds zero_flag, updated on every word op.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
  parameter int HALF_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [2*HALF_W-1:0] opa,
  input  logic [2*HALF_W-1:0] opb,
  output logic                busy,
  output logic                done,
  output logic [2*HALF_W-1:0] result,
  output logic                cy_flag,
  output logic [HALF_W-1:0]   alu_a,
  output logic [HALF_W-1:0]   alu_b,
  output logic [3:0]          alu_aluc,
  output logic                alu_cy_in,
  input  logic [HALF_W-1:0]   alu_z,
  input  logic                alu_cy
`ifdef ALU_SEQ_ZFLAG_EN
  ,
  output logic                zero_flag
`endif
);

  localparam logic [2:0] c_OP_PASS = 3'b000;
  localparam logic [2:0] c_OP_NOT  = 3'b001;
  localparam logic [2:0] c_OP_ADD  = 3'b010;
  localparam logic [2:0] c_OP_ADC  = 3'b011;
  localparam logic [2:0] c_OP_OR   = 3'b100;
  localparam logic [2:0] c_OP_AND  = 3'b101;

  localparam logic [3:0] c_ALUC_PASS = 4'b0000;
  localparam logic [3:0] c_ALUC_NOT  = 4'b0010;
  localparam logic [3:0] c_ALUC_ADD  = 4'b0100;
  localparam logic [3:0] c_ALUC_ADC  = 4'b0101;
  localparam logic [3:0] c_ALUC_OR   = 4'b0110;
  localparam logic [3:0] c_ALUC_AND  = 4'b0111;
  localparam logic [3:0] c_ALUC_CLC  = 4'b1011;
  localparam logic [3:0] c_ALUC_SEC  = 4'b1100;
  localparam logic [3:0] c_ALUC_IDLE = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_FLG  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state_q;
  logic [2:0]            op_q;
  // Low halves go straight to the ALU drive registers at the start edge, so
  // only the high halves need to be held for the second pass.
  logic [HALF_W-1:0]     opa_hi_q;
  logic [HALF_W-1:0]     opb_hi_q;
  logic [2*HALF_W-1:0]   result_q;
  logic                  cy_flag_q;
  logic                  busy_q;
  logic                  done_q;
  logic [HALF_W-1:0]     alu_a_q;
  logic [HALF_W-1:0]     alu_b_q;
  logic [3:0]            alu_aluc_q;
  // Carry into the ALU: cy_flag for the ADC low pass, then the captured
  // low-half carry (c_lo) for the high pass of ADD/ADC.
  logic                  cy_in_q;

  function automatic logic is_arith(input logic [2:0] o);
    return (o == c_OP_ADD) || (o == c_OP_ADC);
  endfunction

  function automatic logic [3:0] lo_aluc(input logic [2:0] o);
    case (o)
      c_OP_PASS: return c_ALUC_PASS;
      c_OP_NOT:  return c_ALUC_NOT;
      c_OP_ADD:  return c_ALUC_ADD;
      c_OP_ADC:  return c_ALUC_ADC;
      c_OP_OR:   return c_ALUC_OR;
      c_OP_AND:  return c_ALUC_AND;
      default:   return c_ALUC_IDLE;
    endcase
  endfunction

  // The high half of both ADD and ADC is an add-with-carry of the chained carry.
  function automatic logic [3:0] hi_aluc(input logic [2:0] o);
    return is_arith(o) ? c_ALUC_ADC : lo_aluc(o);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 3'b000;
      opa_hi_q   <= '0;
      opb_hi_q   <= '0;
      result_q   <= '0;
      cy_flag_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_aluc_q <= c_ALUC_IDLE;
      cy_in_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q     <= op;
            opa_hi_q <= opa[2*HALF_W-1:HALF_W];
            opb_hi_q <= opb[2*HALF_W-1:HALF_W];
            busy_q   <= 1'b1;
            if (op[2:1] == 2'b11) begin
              state_q    <= S_FLG;
              alu_aluc_q <= op[0] ? c_ALUC_SEC : c_ALUC_CLC;
            end else begin
              state_q    <= S_LO;
              alu_a_q    <= opa[HALF_W-1:0];
              alu_b_q    <= opb[HALF_W-1:0];
              alu_aluc_q <= lo_aluc(op);
              cy_in_q    <= (op == c_OP_ADC) ? cy_flag_q : 1'b0;
            end
          end
        end
        S_LO: begin
          result_q[HALF_W-1:0] <= alu_z;
          alu_a_q    <= opa_hi_q;
          alu_b_q    <= opb_hi_q;
          alu_aluc_q <= hi_aluc(op_q);
          cy_in_q    <= is_arith(op_q) ? alu_cy : 1'b0;
          state_q    <= S_HI;
        end
        S_HI: begin
          result_q[2*HALF_W-1:HALF_W] <= alu_z;
          if (is_arith(op_q)) begin
            cy_flag_q <= alu_cy;
          end
          alu_a_q    <= '0;
          alu_b_q    <= '0;
          alu_aluc_q <= c_ALUC_IDLE;
          cy_in_q    <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= S_DONE;
        end
        S_FLG: begin
          cy_flag_q  <= alu_cy;
          alu_aluc_q <= c_ALUC_IDLE;
          done_q     <= 1'b1;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          // A start seen here is deliberately dropped.
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q     <= 1'b0;
          alu_aluc_q <= c_ALUC_IDLE;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_ZFLAG_EN
  logic zero_flag_q;

  // Judged on the full 32-bit word: new high half plus the low half
  // already captured on the LO edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_flag_q <= 1'b0;
    end else if (state_q == S_HI) begin
      zero_flag_q <= ({alu_z, result_q[HALF_W-1:0]} == '0);
    end
  end

  assign zero_flag = zero_flag_q;
`else
  // No zero flag in this build.
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign cy_flag   = cy_flag_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_aluc  = alu_aluc_q;
  assign alu_cy_in = cy_in_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Purpose  : Self-checking bench for alu_seq_ctrl. A behavioural 16-bit ALU
//            answers the sequencer; a 32-bit word-level model predicts
//            result, carry and zero flag for directed and random operations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cy_flag;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_aluc;
  logic        alu_cy_in;
  logic [15:0] alu_z;
  logic        alu_cy;
`ifdef ALU_SEQ_ZFLAG_EN
  logic        zero_flag;
`endif

  int errors = 0;
  int checks = 0;

  // Word-level reference state
  logic [31:0] m_res;
  logic        m_cy;
  logic        m_zf;

  alu_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .opa       (opa),
    .opb       (opb),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cy_flag   (cy_flag),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_aluc  (alu_aluc),
    .alu_cy_in (alu_cy_in),
    .alu_z     (alu_z),
    .alu_cy    (alu_cy)
`ifdef ALU_SEQ_ZFLAG_EN
    ,
    .zero_flag (zero_flag)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU. Logic ops return a parity bit on cy_out so that any
  // wrongful carry capture on those ops is visible.
  always_comb begin
    logic [16:0] s;
    s      = '0;
    alu_z  = 16'hDEAD;
    alu_cy = 1'b1;
    case (alu_aluc)
      4'b0000: begin alu_z = alu_a;          alu_cy = ^alu_a;  end
      4'b0010: begin alu_z = ~alu_a;         alu_cy = ^alu_b;  end
      4'b0100: begin s = {1'b0, alu_a} + {1'b0, alu_b};
                     alu_z = s[15:0];        alu_cy = s[16];   end
      4'b0101: begin s = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cy_in};
                     alu_z = s[15:0];        alu_cy = s[16];   end
      4'b0110: begin alu_z = alu_a | alu_b;  alu_cy = ~^alu_a; end
      4'b0111: begin alu_z = alu_a & alu_b;  alu_cy = ~^alu_b; end
      4'b1011: begin alu_z = 16'h0;          alu_cy = 1'b0;    end
      4'b1100: begin alu_z = 16'h0;          alu_cy = 1'b1;    end
      default: begin alu_z = 16'hDEAD;       alu_cy = 1'b1;    end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 32-bit architectural behaviour of one operation.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    case (o)
      3'd0: m_res = a;
      3'd1: m_res = ~a;
      3'd2: begin s = {1'b0, a} + {1'b0, b}; m_res = s[31:0]; m_cy = s[32]; end
      3'd3: begin s = {1'b0, a} + {1'b0, b} + {32'd0, m_cy}; m_res = s[31:0]; m_cy = s[32]; end
      3'd4: m_res = a | b;
      3'd5: m_res = a & b;
      3'd6: m_cy = 1'b0;
      default: m_cy = 1'b1;
    endcase
    if (o[2:1] != 2'b11) m_zf = (m_res == 32'd0);
  endtask

  task automatic check_outcome();
    check("result", result, m_res);
    check("cy_flag", 32'(cy_flag), 32'(m_cy));
`ifdef ALU_SEQ_ZFLAG_EN
    check("zero_flag", 32'(zero_flag), 32'(m_zf));
`endif
  endtask

  // One operation: start on a negedge, then walk the expected latency,
  // scrambling the operand inputs and optionally holding start high.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit noise);
    bit          flag;
    int          lat;
    logic [3:0]  e_lo, e_hi;
    logic        cy0, cin_lo, cin_hi;
    logic [16:0] lsum;
    flag = (o[2:1] == 2'b11);
    lat  = flag ? 2 : 3;
    case (o)
      3'd0: begin e_lo = 4'b0000; e_hi = 4'b0000; end
      3'd1: begin e_lo = 4'b0010; e_hi = 4'b0010; end
      3'd2: begin e_lo = 4'b0100; e_hi = 4'b0101; end
      3'd3: begin e_lo = 4'b0101; e_hi = 4'b0101; end
      3'd4: begin e_lo = 4'b0110; e_hi = 4'b0110; end
      3'd5: begin e_lo = 4'b0111; e_hi = 4'b0111; end
      3'd6: begin e_lo = 4'b1011; e_hi = 4'b1011; end
      default: begin e_lo = 4'b1100; e_hi = 4'b1100; end
    endcase
    cy0    = m_cy;
    cin_lo = (o == 3'd3) ? cy0 : 1'b0;
    lsum   = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cin_lo};
    cin_hi = lsum[16];
    model(o, a, b);

    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      start = noise;
      op    = 3'($urandom);
      opa   = $urandom;
      opb   = $urandom;
      check("busy", 32'(busy), 32'd1);
      check("done", 32'(done), (k == lat) ? 32'd1 : 32'd0);
      if (k == 1) begin
        check("aluc_first", 32'(alu_aluc), 32'(e_lo));
        if (!flag) begin
          check("alu_a_lo", 32'(alu_a), 32'(a[15:0]));
          check("alu_b_lo", 32'(alu_b), 32'(b[15:0]));
          if (o == 3'd2 || o == 3'd3) check("cy_in_lo", 32'(alu_cy_in), 32'(cin_lo));
        end
      end
      if (k == 2 && !flag) begin
        check("aluc_hi", 32'(alu_aluc), 32'(e_hi));
        check("alu_a_hi", 32'(alu_a), 32'(a[31:16]));
        check("alu_b_hi", 32'(alu_b), 32'(b[31:16]));
        if (o == 3'd2 || o == 3'd3) check("cy_in_hi", 32'(alu_cy_in), 32'(cin_hi));
      end
      if (k == lat) check_outcome();
    end
    // Any start held through DONE must have been dropped.
    @(posedge clk); #1;
    start = 1'b0;
    check("done_after", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("aluc_idle", 32'(alu_aluc), 32'h8);
    check("alu_a_idle", 32'(alu_a), 32'd0);
    check_outcome();
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; start = 1'b0; op = 3'd0; opa = '0; opb = '0;
    m_res = '0; m_cy = 1'b0; m_zf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_aluc", 32'(alu_aluc), 32'h8);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_cy_in", 32'(alu_cy_in), 32'd0);
    check_outcome();
    @(negedge clk);
    rst = 1'b0;

    // Directed scenarios
    run_op(3'd2, 32'h0000FFFF, 32'h00000001, 1'b0);
    check("tp_add_res", result, 32'h00010000);
    run_op(3'd2, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    check("tp_wrap_res", result, 32'h00000000);
    check("tp_wrap_cy", 32'(cy_flag), 32'd1);
    run_op(3'd1, 32'h12345678, 32'h00000000, 1'b0);
    check("tp_not_res", result, 32'hEDCBA987);
    check("tp_not_cy", 32'(cy_flag), 32'd1);
    run_op(3'd7, 32'h0, 32'h0, 1'b0);
    run_op(3'd3, 32'h1, 32'h1, 1'b0);
    check("tp_adc_res", result, 32'h00000003);
    run_op(3'd6, 32'h0, 32'h0, 1'b0);
    check("tp_clc_res", result, 32'h00000003);
    check("tp_clc_cy", 32'(cy_flag), 32'd0);
    run_op(3'd2, 32'h11112222, 32'h3333EEEE, 1'b1);

    // Reset while the OR is in its high pass
    @(negedge clk);
    start = 1'b1; op = 3'd4; opa = 32'hF0F00000; opb = 32'h0F0F0001;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    check("or_in_hi", 32'(alu_aluc), 32'h6);
    rst = 1'b1;
    #1;
    m_res = '0; m_cy = 1'b0; m_zf = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_aluc", 32'(alu_aluc), 32'h8);
    check_outcome();
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("mrst_no_done", 32'(seen_done), 32'd0);
    check("mrst_busy_after", 32'(busy), 32'd0);

    run_op(3'd5, 32'hFFFF0000, 32'h00FF00FF, 1'b0);
    check("tp_and_res", result, 32'h00FF0000);

    // Random operations, with random start noise during busy
    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), $urandom, $urandom, bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
